qpmm_poly2int: RTL

QPMM_POLY2INT -- requirements
Module: qpmm_poly2int

---
 rtl/qpmm_poly2int.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/qpmm_poly2int.sv
// qpmm_poly2int: folds a redundant 18-coefficient QPMM result into a canonical K*N-bit integer (one conditional MOD subtract).
// Latency: fixed; out_valid rises after the 36th rising edge following input acceptance.
// Backpressure: one operation in flight; in_ready stays low until the result handshake, result held while out_ready is low.
module qpmm_poly2int #(
  parameter int K = 16,
  parameter int N = 17,
  parameter int M = 17,
  parameter logic [K*N-1:0] MOD = {16'h0, 256'h2523648240000001ba344d80000000086121000000000013a700000000000013}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M:0][47:0]   in_S,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K*N-1:0]     out_Z,
  output logic               out_ovf
);

  localparam int CW = $clog2(((M > N) ? M : N) + 1);
  // 48-bit coefficient plus running carry; the carry never exceeds AW-K bits
  localparam int AW = 49;
  localparam int BW = AW - K;
  localparam logic [N-1:0][K-1:0] MOD_L = MOD;

  typedef enum logic [1:0] {IDLE, PROP, SUB, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         carry_q, carry_d;
  logic                  borrow_q, borrow_d;
  logic                  ovf_q, ovf_d;
  logic [M:0][47:0]      s_q, s_d;
  logic [N-1:0][K-1:0]   limb_q, limb_d;
  logic [N-1:0][K-1:0]   diff_q, diff_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_ovf_q, out_ovf_d;
  logic [K*N-1:0]        out_z_q, out_z_d;
  logic [AW-1:0]         acc;
  logic [K:0]            sub;

  // next-state: carry propagation one coefficient per cycle, then limb-serial subtract of MOD
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    s_d         = s_q;
    limb_d      = limb_q;
    diff_d      = diff_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    out_z_d     = out_z_q;
    acc = AW'(s_q[cnt_q]) + AW'(carry_q);
    sub = {1'b0, limb_q[cnt_q]} - {1'b0, MOD_L[cnt_q]} - {{K{1'b0}}, borrow_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d        = in_S;
          cnt_d      = '0;
          carry_d    = '0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = PROP;
        end
      end
      PROP: begin
        // limbs at or above N do not fit in the output: any content there is overflow
        if (cnt_q < CW'(N)) begin
          limb_d[cnt_q] = acc[K-1:0];
        end else if (acc[K-1:0] != '0) begin
          ovf_d = 1'b1;
        end
        carry_d = acc[AW-1:K];
        if (cnt_q == CW'(M)) begin
          if (acc[AW-1:K] != '0) begin
            ovf_d = 1'b1;
          end
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = SUB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SUB: begin
        diff_d[cnt_q] = sub[K-1:0];
        borrow_d      = sub[K];
        if (cnt_q == CW'(N-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // first DONE cycle registers the selected result; afterwards hold until handshake
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_z_d     = borrow_q ? limb_q : diff_q;
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      s_q         <= '0;
      limb_q      <= '0;
      diff_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      s_q         <= s_d;
      limb_q      <= limb_d;
      diff_q      <= diff_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_z_q     <= out_z_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_Z     = out_z_q;
  assign out_ovf   = out_ovf_q;

endmodule
